// File: rtl/srv32_dbus_router.sv
// srv32 data-bus router: decodes addr[31:28] onto NSLV targets plus an internal error sink.
// Optional macro SRV32_DBUS_TIMEOUT_EN adds per-channel accept timeouts of TIMEOUT cycles.
module srv32_dbus_router #(
  parameter int unsigned         NSLV     = 2,
  parameter logic [NSLV*4-1:0]   SLV_BASE = {4'hC, 4'h0},
  parameter int unsigned         TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 m_wready,
  output logic                 m_wvalid,
  input  logic [31:0]          m_waddr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  input  logic                 m_rready,
  output logic                 m_rvalid,
  input  logic [31:0]          m_raddr,
  output logic                 m_rresp,
  output logic [31:0]          m_rdata,
  output logic [NSLV-1:0]      s_wready,
  input  logic [NSLV-1:0]      s_wvalid,
  output logic [31:0]          s_waddr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  output logic [NSLV-1:0]      s_rready,
  input  logic [NSLV-1:0]      s_rvalid,
  output logic [31:0]          s_raddr,
  input  logic [NSLV-1:0]      s_rresp,
  input  logic [NSLV*32-1:0]   s_rdata,
  input  logic                 err_clr,
  output logic                 bus_err,
  output logic [31:0]          err_addr,
  output logic                 err_wr
);

  // Select index NSLV denotes the internal error target.
  localparam logic [3:0] ErrSel = 4'(NSLV);

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1) begin : g_param_check
    $error("srv32_dbus_router: NSLV must be 1..8 and TIMEOUT at least 1");
  end

  // Lowest index wins on overlapping bases.
  function automatic logic [3:0] decode(input logic [3:0] nib);
    logic [3:0] sel;
    sel = ErrSel;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if (nib == SLV_BASE[4*i +: 4]) sel = 4'(i);
    end
    return sel;
  endfunction

  logic [3:0] w_wsel, w_rsel, w_rsel_eff;
  logic       w_wmapped, w_rmapped;
  logic       w_wtgt_acc, w_rtgt_acc;
  logic       w_wto, w_rto;
  logic       w_werr_acc, w_rerr_acc;
  logic       w_rd_acc;

  logic [3:0]  r_rd_sel;
  logic        r_bus_err;
  logic [31:0] r_err_addr;
  logic        r_err_wr;

  assign w_wsel    = decode(m_waddr[31:28]);
  assign w_rsel    = decode(m_raddr[31:28]);
  assign w_wmapped = (w_wsel != ErrSel);
  assign w_rmapped = (w_rsel != ErrSel);

  assign s_waddr = m_waddr;
  assign s_wdata = m_wdata;
  assign s_wstrb = m_wstrb;
  assign s_raddr = m_raddr;

  always_comb begin
    s_wready   = '0;
    s_rready   = '0;
    w_wtgt_acc = 1'b0;
    w_rtgt_acc = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (w_wsel == 4'(i)) begin
        s_wready[i] = m_wready;
        w_wtgt_acc  = s_wvalid[i];
      end
      if (w_rsel == 4'(i)) begin
        s_rready[i] = m_rready;
        w_rtgt_acc  = s_rvalid[i];
      end
    end
  end

`ifdef SRV32_DBUS_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_wcnt, r_rcnt;

  assign w_wto = m_wready & (r_wcnt == CntW'(TIMEOUT));
  assign w_rto = m_rready & (r_rcnt == CntW'(TIMEOUT));

  // Counters run only while a request waits; any accept or drop restarts them.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      r_wcnt <= (m_wready & ~m_wvalid) ? r_wcnt + CntW'(1) : '0;
      r_rcnt <= (m_rready & ~m_rvalid) ? r_rcnt + CntW'(1) : '0;
    end
  end
`else
  assign w_wto = 1'b0;
  assign w_rto = 1'b0;
`endif

  // A target accepting in the timeout cycle completes normally.
  assign m_wvalid   = w_wmapped ? (w_wtgt_acc | w_wto) : m_wready;
  assign m_rvalid   = w_rmapped ? (w_rtgt_acc | w_rto) : m_rready;
  assign w_werr_acc = m_wready & (~w_wmapped | (w_wto & ~w_wtgt_acc));
  assign w_rerr_acc = m_rready & (~w_rmapped | (w_rto & ~w_rtgt_acc));
  assign w_rsel_eff = w_rerr_acc ? ErrSel : w_rsel;
  assign w_rd_acc   = m_rready & m_rvalid;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_rd_sel <= '0;
    end else if (w_rd_acc) begin
      r_rd_sel <= w_rsel_eff;
    end
  end

  always_comb begin
    m_rdata = '0;
    m_rresp = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (r_rd_sel == 4'(i)) begin
        m_rdata = s_rdata[32*i +: 32];
        m_rresp = s_rresp[i];
      end
    end
  end

  // First error is kept until cleared; a new error in the clear cycle reloads the fields.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
      r_err_wr   <= 1'b0;
    end else if (w_werr_acc | w_rerr_acc) begin
      r_bus_err <= 1'b1;
      if (!r_bus_err || err_clr) begin
        r_err_addr <= w_werr_acc ? m_waddr : m_raddr;
        r_err_wr   <= w_werr_acc;
      end
    end else if (err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign bus_err  = r_bus_err;
  assign err_addr = r_err_addr;
  assign err_wr   = r_err_wr;

endmodule

// File: tb/tb_srv32_dbus_router.sv
// Self-checking bench for srv32_dbus_router (NSLV=2, bases {C,0}); read data checked by scoreboard.
module tb_srv32_dbus_router;

  localparam logic [31:0] D0 = 32'h5555_0000;
  localparam logic [31:0] D1 = 32'hAAAA_0001;
`ifdef SRV32_DBUS_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetb;
  logic        m_wready, m_wvalid, m_rready, m_rvalid, m_rresp;
  logic [31:0] m_waddr, m_wdata, m_raddr, m_rdata;
  logic [3:0]  m_wstrb, s_wstrb;
  logic [1:0]  s_wready, s_wvalid, s_rready, s_rvalid, s_rresp;
  logic [31:0] s_waddr, s_wdata, s_raddr;
  logic [63:0] s_rdata;
  logic        err_clr, bus_err, err_wr;
  logic [31:0] err_addr;

  int n_checks = 0;
  int n_errors = 0;

  srv32_dbus_router #(
    .NSLV     (2),
    .SLV_BASE ({4'hC, 4'h0}),
    .TIMEOUT  (4)
  ) u_dut (
    .clk      (clk),
    .resetb   (resetb),
    .m_wready (m_wready),
    .m_wvalid (m_wvalid),
    .m_waddr  (m_waddr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rready (m_rready),
    .m_rvalid (m_rvalid),
    .m_raddr  (m_raddr),
    .m_rresp  (m_rresp),
    .m_rdata  (m_rdata),
    .s_wready (s_wready),
    .s_wvalid (s_wvalid),
    .s_waddr  (s_waddr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rready (s_rready),
    .s_rvalid (s_rvalid),
    .s_raddr  (s_raddr),
    .s_rresp  (s_rresp),
    .s_rdata  (s_rdata),
    .err_clr  (err_clr),
    .bus_err  (bus_err),
    .err_addr (err_addr),
    .err_wr   (err_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: nibble 0 -> target 0, nibble C -> target 1, else error (2).
  function automatic int tgt(input logic [31:0] addr);
    if (addr[31:28] == 4'h0) return 0;
    if (addr[31:28] == 4'hC) return 1;
    return 2;
  endfunction

  // Scoreboard: predict accepts from the reference model, compare read data one cycle later.
  logic [32:0] sb_q[$];
  logic [32:0] sb_exp;
  bit          sb_pend = 1'b0;
  int          sb_cnt  = 0;
  int          sb_t, sb_wt;
  bit          sb_tacc, sb_to, sb_acc, sb_wacc;

  always @(negedge clk) begin
    if (!resetb) begin
      sb_q.delete();
      sb_pend = 1'b0;
      sb_cnt  = 0;
    end else begin
      if (sb_pend) begin
        if (sb_q.size() == 0) begin
          check("rd_queue", 1, 0);
        end else begin
          sb_exp = sb_q.pop_front();
          check("rdata", {m_rresp, m_rdata}, sb_exp);
        end
      end
      sb_t    = tgt(m_raddr);
      sb_tacc = (sb_t < 2) ? s_rvalid[sb_t] : 1'b0;
      sb_to   = ToEn && (sb_cnt == 4);
      sb_acc  = m_rready && (sb_t == 2 || sb_tacc || sb_to);
      if (m_rready) check("m_rvalid", m_rvalid, sb_acc);
      sb_pend = sb_acc;
      if (sb_acc) begin
        if (sb_t == 2 || !sb_tacc) sb_q.push_back(33'd0);
        else sb_q.push_back({s_rresp[sb_t], (sb_t == 0) ? D0 : D1});
      end
      sb_cnt = (m_rready && !sb_acc) ? sb_cnt + 1 : 0;
      sb_wt   = tgt(m_waddr);
      sb_wacc = (sb_wt == 2) ? 1'b1 : s_wvalid[sb_wt];
      if (m_wready) check("m_wvalid", m_wvalid, sb_wacc);
    end
  end

  initial begin
    resetb   = 1'b0;
    m_wready = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
    m_wstrb  = '0;
    m_rready = 1'b0;
    m_raddr  = '0;
    s_wvalid = '0;
    s_rvalid = '0;
    s_rresp  = 2'b11;
    s_rdata  = {D1, D0};
    err_clr  = 1'b0;
    #7;
    check("rst_rdata", m_rdata, D0);
    check("rst_rresp", m_rresp, 1'b1);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_err_wr", err_wr, 1'b0);
    #5 resetb = 1'b1;
    tick();

    // Mapped write to target 0, accept delayed one cycle.
    m_wready = 1'b1; m_waddr = 32'h0000_0010; m_wdata = 32'h1234_5678; m_wstrb = 4'hF;
    @(negedge clk);
    check("w_sready", s_wready, 2'b01);
    check("w_valid_wait", m_wvalid, 1'b0);
    check("w_saddr", s_waddr, 32'h0000_0010);
    check("w_sdata", s_wdata, 32'h1234_5678);
    check("w_sstrb", s_wstrb, 4'hF);
    tick();
    s_wvalid = 2'b01;
    @(negedge clk);
    check("w_valid_acc", m_wvalid, 1'b1);
    tick();
    m_wready = 1'b0; s_wvalid = '0;
    @(negedge clk);
    check("w_bus_err", bus_err, 1'b0);
    tick();

    // Back-to-back reads: target 1 then target 0.
    m_rready = 1'b1; m_raddr = 32'hC000_0004; s_rvalid = 2'b10;
    @(negedge clk);
    check("r1_sready", s_rready, 2'b10);
    check("r1_saddr", s_raddr, 32'hC000_0004);
    tick();
    m_raddr = 32'h0000_0000; s_rvalid = 2'b01;
    @(negedge clk);
    check("r0_sready", s_rready, 2'b01);
    tick();
    m_rready = 1'b0; s_rvalid = '0;
    @(negedge clk);
    tick();

    // Concurrent write to target 0 and read from target 1.
    m_wready = 1'b1; m_waddr = 32'h0000_0020; s_wvalid = 2'b01;
    m_rready = 1'b1; m_raddr = 32'hC000_0008; s_rvalid = 2'b10;
    @(negedge clk);
    check("dual_sw", s_wready, 2'b01);
    check("dual_sr", s_rready, 2'b10);
    tick();
    m_wready = 1'b0; m_rready = 1'b0; s_wvalid = '0; s_rvalid = '0;
    @(negedge clk);
    tick();

    // Request dropped before accept leaves no trace.
    m_wready = 1'b1; m_waddr = 32'hC000_0000; s_wvalid = '0;
    @(negedge clk);
    check("drop_sw", s_wready, 2'b10);
    tick();
    m_wready = 1'b0;
    @(negedge clk);
    check("drop_err", bus_err, 1'b0);
    tick();

    // Unmapped read.
    m_rready = 1'b1; m_raddr = 32'h5000_0000;
    @(negedge clk);
    check("ur_sready", s_rready, 2'b00);
    tick();
    m_rready = 1'b0;
    @(negedge clk);
    check("ur_bus_err", bus_err, 1'b1);
    check("ur_err_addr", err_addr, 32'h5000_0000);
    check("ur_err_wr", err_wr, 1'b0);
    tick();

    // Clear alone: flag drops, fields hold.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("clr_bus_err", bus_err, 1'b0);
    check("clr_err_addr", err_addr, 32'h5000_0000);
    tick();

    // Simultaneous write and read errors: write captured.
    m_wready = 1'b1; m_waddr = 32'h7000_0008;
    m_rready = 1'b1; m_raddr = 32'h6000_0000;
    tick();
    m_wready = 1'b0; m_rready = 1'b0;
    @(negedge clk);
    check("wr_bus_err", bus_err, 1'b1);
    check("wr_err_addr", err_addr, 32'h7000_0008);
    check("wr_err_wr", err_wr, 1'b1);
    tick();
    m_rready = 1'b1; m_raddr = 32'h9000_0000;
    tick();
    m_rready = 1'b0;
    @(negedge clk);
    check("keep_err_addr", err_addr, 32'h7000_0008);
    check("keep_err_wr", err_wr, 1'b1);
    tick();

    // Clear together with a new error: new error wins.
    err_clr = 1'b1; m_wready = 1'b1; m_waddr = 32'h8000_0000;
    tick();
    err_clr = 1'b0; m_wready = 1'b0;
    @(negedge clk);
    check("clrnew_bus_err", bus_err, 1'b1);
    check("clrnew_err_addr", err_addr, 32'h8000_0000);
    check("clrnew_err_wr", err_wr, 1'b1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("clr2_bus_err", bus_err, 1'b0);
    check("clr2_err_addr", err_addr, 32'h8000_0000);
    tick();

`ifdef SRV32_DBUS_TIMEOUT_EN
    // Stalled read on target 0 times out after 4 waiting cycles.
    m_rready = 1'b1; m_raddr = 32'h0000_0000; s_rvalid = '0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      check("to_rvalid", m_rvalid, (k == 4));
      check("to_sready", s_rready, 2'b01);
      if (k < 4) tick();
    end
    tick();
    m_rready = 1'b0;
    @(negedge clk);
    check("to_bus_err", bus_err, 1'b1);
    check("to_err_addr", err_addr, 32'h0000_0000);
    check("to_err_wr", err_wr, 1'b0);
    tick();

    // Reset mid-wait: counter restarts, error flag cleared.
    m_rready = 1'b1;
    tick();
    tick();
    resetb = 1'b0;
    @(negedge clk);
    check("rst_mid_err", bus_err, 1'b0);
    check("rst_mid_rdata", m_rdata, D0);
    tick();
    resetb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_pulse", m_rvalid, 1'b0);
      tick();
    end
    m_rready = 1'b0;
    @(negedge clk);
    check("rst_end_err", bus_err, 1'b0);
    tick();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
